// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: RAM request port, decode handshake, redirect.
// master = fetch unit, slave = memory controller / decode side.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              fetch_en;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    input  fetch_en, mem_gnt, mem_rvalid, mem_rdata,
    input  instr_ready, redirect_valid, redirect_pc,
    output mem_req, mem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output fetch_en, mem_gnt, mem_rvalid, mem_rdata,
    output instr_ready, redirect_valid, redirect_pc,
    input  mem_req, mem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues RAM reads, buffers words in a
// prefetch FIFO and hands them to decode; redirect flushes all.
module instr_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic clk,
  input logic rst,
  instr_fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              inflight_q, inflight_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [ADDR_W-1:0] tag_q  [DEPTH];
  logic [ADDR_W-1:0] tag_d  [DEPTH];

  logic          credit;
  logic          req;
  logic          accept;
  logic          push;
  logic          pop;
  logic          valid;
  logic [CW:0]   used;

  assign used   = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};
  assign credit = used < (CW+1)'(DEPTH);
  assign req    = (state_q == RUN) && credit && !bus.redirect_valid;
  assign accept = req && bus.mem_gnt;
  assign valid  = cnt_q != '0;
  assign push   = bus.mem_rvalid && inflight_q &&
                  (state_q != DISCARD) && !bus.redirect_valid;
  assign pop    = valid && bus.instr_ready && !bus.redirect_valid;

  assign bus.mem_req     = req;
  assign bus.mem_addr    = req ? pc_q : addr_q;
  assign bus.instr_valid = valid;
  assign bus.instr       = valid ? data_q[rd_q] : '0;
  assign bus.instr_pc    = valid ? tag_q[rd_q] : '0;

  // Next fetch state; a redirect with a word in flight forces DISCARD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.fetch_en) state_d = RUN;
      RUN:     if (!bus.fetch_en) state_d = IDLE;
      DISCARD: state_d = bus.fetch_en ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.redirect_valid && inflight_q) state_d = DISCARD;
  end

  // PC, request tracking and FIFO pointer/storage updates.
  always_comb begin
    pc_d       = pc_q;
    addr_d     = bus.mem_addr;
    req_addr_d = req_addr_q;
    inflight_d = inflight_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    tag_d      = tag_q;

    if (accept) begin
      pc_d       = pc_q + ADDR_W'(1);
      req_addr_d = pc_q;
      inflight_d = 1'b1;
    end else if (bus.mem_rvalid || state_q == DISCARD) begin
      inflight_d = 1'b0;
    end

    if (push) begin
      data_d[wr_q] = bus.mem_rdata;
      tag_d[wr_q]  = req_addr_q;
      wr_d         = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);

    unique case (1'b1)
      push && !pop: cnt_d = cnt_q + CW'(1);
      pop && !push: cnt_d = cnt_q - CW'(1);
      default:      cnt_d = cnt_q;
    endcase

    if (bus.redirect_valid) begin
      pc_d  = bus.redirect_pc;
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      addr_q     <= '0;
      req_addr_q <= '0;
      inflight_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      data_q     <= '{default: '0};
      tag_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a one-cycle RAM model
// returning 0xA000_0000 + address.
module tb_instr_fetch_unit;
  logic clk;
  logic rst;
  logic rv_q;
  logic [31:0] rd_q;
  logic stray;
  int total;
  int bad;

  instr_fetch_unit_if #(.ADDR_W(16), .DATA_W(32)) bus();

  instr_fetch_unit #(.ADDR_W(16), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data returns the cycle after an accepted request.
  always @(posedge clk) begin
    rv_q <= bus.mem_req && bus.mem_gnt;
    rd_q <= 32'hA000_0000 + {16'h0, bus.mem_addr};
  end

  assign bus.mem_rvalid = rv_q | stray;
  assign bus.mem_rdata  = rd_q;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic hard_reset();
    rst = 1'b0;
    bus.fetch_en = 1'b0;
    bus.mem_gnt = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    stray = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  logic [15:0] t3_addr [7];
  logic        t3_v    [7];
  logic [15:0] t3_pc   [7];
  logic        t3_gnt  [7];

  initial begin
    total = 0;
    bad = 0;
    t3_gnt  = '{1, 0, 1, 0, 1, 0, 1};
    t3_addr = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3};
    t3_v    = '{0, 0, 1, 0, 1, 0, 1};
    t3_pc   = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd2};

    rst = 1'b0;
    bus.fetch_en = 1'b0;
    bus.mem_gnt = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    stray = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_req", 32'(bus.mem_req), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_pc", 32'(bus.instr_pc), 0);

    // streaming
    rst = 1'b1;
    bus.fetch_en = 1'b1;
    bus.mem_gnt = 1'b1;
    bus.instr_ready = 1'b1;
    #1;
    chk("s_idle_req", 32'(bus.mem_req), 0);
    tick(); #1;
    chk("s_req0", 32'(bus.mem_req), 1);
    chk("s_addr0", 32'(bus.mem_addr), 0);
    chk("s_v0", 32'(bus.instr_valid), 0);
    tick(); #1;
    chk("s_addr1", 32'(bus.mem_addr), 1);
    chk("s_v1", 32'(bus.instr_valid), 0);
    tick(); #1;
    chk("s_v2", 32'(bus.instr_valid), 1);
    chk("s_instr0", bus.instr, 32'hA000_0000);
    chk("s_pc0", 32'(bus.instr_pc), 0);
    chk("s_addr2", 32'(bus.mem_addr), 2);
    for (int n = 1; n <= 5; n++) begin
      tick(); #1;
      chk("s_valid", 32'(bus.instr_valid), 1);
      chk("s_instr", bus.instr, 32'hA000_0000 + 32'(n));
      chk("s_pc", 32'(bus.instr_pc), 32'(n));
    end

    // back-pressure fills the FIFO
    hard_reset();
    bus.fetch_en = 1'b1;
    bus.mem_gnt = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("bp_req", 32'(bus.mem_req), 0);
    chk("bp_addr", 32'(bus.mem_addr), 3);
    chk("bp_head", bus.instr, 32'hA000_0000);
    chk("bp_pc", 32'(bus.instr_pc), 0);
    tick(); #1;
    chk("bp_req2", 32'(bus.mem_req), 0);
    chk("bp_head2", bus.instr, 32'hA000_0000);
    tick();
    bus.instr_ready = 1'b1;
    #1;
    chk("bp_head3", 32'(bus.instr_pc), 0);
    for (int k = 1; k <= 5; k++) begin
      tick(); #1;
      chk("dr_valid", 32'(bus.instr_valid), 1);
      chk("dr_pc", 32'(bus.instr_pc), 32'(k));
      chk("dr_instr", bus.instr, 32'hA000_0000 + 32'(k));
    end

    // grant toggling
    hard_reset();
    bus.fetch_en = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      bus.mem_gnt = t3_gnt[i];
      #1;
      chk("g_req", 32'(bus.mem_req), 1);
      chk("g_addr", 32'(bus.mem_addr), 32'(t3_addr[i]));
      chk("g_valid", 32'(bus.instr_valid), 32'(t3_v[i]));
      if (t3_v[i]) chk("g_pc", 32'(bus.instr_pc), 32'(t3_pc[i]));
      tick();
    end

    // redirect with a word in flight and two buffered
    hard_reset();
    bus.fetch_en = 1'b1;
    bus.mem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    #1;
    chk("rd_pre_addr", 32'(bus.mem_addr), 3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'h0040;
    #1;
    chk("rd_req_off", 32'(bus.mem_req), 0);
    chk("rd_valid_pre", 32'(bus.instr_valid), 1);
    tick();
    bus.redirect_valid = 1'b0;
    stray = 1'b1;
    #1;
    chk("rd_flush", 32'(bus.instr_valid), 0);
    chk("rd_disc_req", 32'(bus.mem_req), 0);
    tick();
    stray = 1'b0;
    bus.instr_ready = 1'b1;
    #1;
    chk("rd_disc_drop", 32'(bus.instr_valid), 0);
    chk("rd_new_req", 32'(bus.mem_req), 1);
    chk("rd_new_addr", 32'(bus.mem_addr), 32'h40);
    tick(); #1;
    chk("rd_addr41", 32'(bus.mem_addr), 32'h41);
    chk("rd_v_lat", 32'(bus.instr_valid), 0);
    tick(); #1;
    chk("rd_v", 32'(bus.instr_valid), 1);
    chk("rd_pc", 32'(bus.instr_pc), 32'h40);
    chk("rd_instr", bus.instr, 32'hA000_0040);

    // redirect near the top of the address space
    hard_reset();
    bus.fetch_en = 1'b1;
    bus.mem_gnt = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    #1;
    chk("w_req_off", 32'(bus.mem_req), 0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("w_addr_fffe", 32'(bus.mem_addr), 32'hFFFE);
    tick(); #1;
    chk("w_addr_ffff", 32'(bus.mem_addr), 32'hFFFF);
    tick(); #1;
    chk("w_addr_0", 32'(bus.mem_addr), 0);
    chk("w_pc_fffe", 32'(bus.instr_pc), 32'hFFFE);
    chk("w_ins_fffe", bus.instr, 32'hA000_FFFE);
    tick(); #1;
    chk("w_addr_1", 32'(bus.mem_addr), 1);
    chk("w_pc_ffff", 32'(bus.instr_pc), 32'hFFFF);
    tick(); #1;
    chk("w_pc_0", 32'(bus.instr_pc), 0);
    chk("w_ins_0", bus.instr, 32'hA000_0000);

    // reset with FIFO at credit limit and a word in flight
    hard_reset();
    bus.fetch_en = 1'b1;
    bus.mem_gnt = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("mr_req_full", 32'(bus.mem_req), 0);
    chk("mr_valid_pre", 32'(bus.instr_valid), 1);
    rst = 1'b0;
    #1;
    chk("mr_valid", 32'(bus.instr_valid), 0);
    chk("mr_addr", 32'(bus.mem_addr), 0);
    chk("mr_instr", bus.instr, 0);
    chk("mr_pc", 32'(bus.instr_pc), 0);
    tick();
    rst = 1'b1;
    bus.fetch_en = 1'b0;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    #1;
    chk("mr_stray", 32'(bus.instr_valid), 0);
    chk("mr_idle_req", 32'(bus.mem_req), 0);
    bus.fetch_en = 1'b1;
    tick(); #1;
    chk("mr_req", 32'(bus.mem_req), 1);
    chk("mr_addr0", 32'(bus.mem_addr), 0);
    tick();
    tick(); #1;
    chk("mr_re_pc", 32'(bus.instr_pc), 0);
    chk("mr_re_ins", bus.instr, 32'hA000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end fetch stage that sits directly upstream of the CPU decode/execute stage.
- Owns the program counter and issues instruction reads to the shared RAM port; the memory controller arbitrates that port between fetch and LDR/STR data accesses.
- Buffers fetched words in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Supports redirect (branch/PC load) with flush of buffered and in-flight words.

Parameters:
- ADDR_W, 16, instruction address / PC width
- DATA_W, 32, instruction word width
- DEPTH, 4, prefetch FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- fetch_en  in  1  1 = fetching allowed; 0 = stop issuing new requests
- mem_req  out  1  fetch requests the address bus this cycle
- mem_addr  out  ADDR_W  fetch address, valid while mem_req=1
- mem_gnt  in  1  controller grants the bus to fetch; a request is accepted when mem_req && mem_gnt at a rising edge
- mem_rvalid  in  1  read data valid; high exactly one cycle after an accepted request
- mem_rdata  in  DATA_W  read data
- instr_valid  out  1  FIFO head holds a valid instruction
- instr  out  DATA_W  FIFO head instruction word
- instr_pc  out  ADDR_W  address the head word was fetched from
- instr_ready  in  1  decode consumes the head when instr_valid && instr_ready at an edge
- redirect_valid  in  1  load a new PC and flush
- redirect_pc  in  ADDR_W  new fetch address

Behaviour:
- Reset (rst=0, async): pc=0, FIFO empty, inflight=0, state=IDLE. Outputs mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0.
- FSM states:
  - IDLE: no requests. Goes to RUN when fetch_en=1.
  - RUN: issues requests. Goes to IDLE when fetch_en=0; an in-flight response is still accepted.
  - DISCARD: entered on redirect while inflight=1. Lasts 1 cycle, drops the returning word, then goes to RUN, or to IDLE if fetch_en=0.
- Credit rule:
  - mem_req = (state==RUN) && (fifo_count + inflight < DEPTH) && !redirect_valid.
  - mem_addr = pc while mem_req=1, otherwise holds its last value.
- Accepted request: pc <= pc+1 (wraps 0xFFFF→0x0000 for ADDR_W=16), inflight <= 1. The request address is recorded for instr_pc.
- Response: at most 1 request is outstanding per cycle; back-to-back issue each cycle is allowed.
  - On mem_rvalid with inflight=1 and not discarding, {mem_rdata, addr} is written to the FIFO tail at that edge.
  - instr_valid rises the following cycle.
  - Minimum latency: grant at edge k → instr_valid high after edge k+1.
  - Throughput: 1 instruction/cycle with mem_gnt=1 and instr_ready=1.
- mem_rvalid with inflight=0 is ignored.
- instr, instr_valid and instr_pc are driven combinationally from the FIFO head; the head word is stable while instr_valid && !instr_ready.
- Simultaneous push and pop on a non-full/non-empty FIFO: count unchanged.
- Full FIFO: the credit rule guarantees no overflow and mem_req stays low.
- Redirect (priority over everything else):
  - At the edge: FIFO cleared (count=0), pc <= redirect_pc, pending pop ignored.
  - A response arriving in the same cycle is dropped.
  - A request outstanding at the edge goes to DISCARD and its data is dropped.
  - mem_req=0 in the redirect cycle.
  - First request to redirect_pc is issued the cycle after the redirect, or 2 cycles after if DISCARD is entered.
- mem_gnt=0 stalls issue; pc and mem_addr hold; no timeout.
- fetch_en falling: no new requests; FIFO contents are kept and still drain to decode.
- Reset mid-operation: all state is cleared immediately; the post-reset in-flight response is ignored because inflight=0.

Test Plan:
- Reset release, fetch_en=1, mem_gnt=1, RAM word[n]=0xA000_0000+n, instr_ready=1 → mem_addr 0,1,2,…; instr_valid rises 2 edges after first grant; instr/instr_pc stream A000_0000/0, A000_0001/1, … one per cycle.
- instr_ready=0 with gnt=1 → exactly DEPTH=4 words buffered; mem_req low once count+inflight=4; head stays 0xA000_0000/pc 0; releasing ready drains 4 words in order with no gap.
- mem_gnt toggling 1,0,1,0 → mem_addr holds during gnt=0; no duplicated or skipped pc; output order stays 0,1,2,…
- redirect_valid with redirect_pc=0x0040 while a request is in flight and FIFO holds 2 → instr_valid drops the next cycle, in-flight word dropped (DISCARD), next mem_addr=0x0040, first instr_pc=0x0040.
- Redirect to 0xFFFE with gnt=1 → fetch addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- rst asserted while FIFO is full and a request is in flight → all outputs 0 immediately; the stray mem_rvalid in the next cycle causes no FIFO write; refetch restarts at pc 0.
